// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Counter width for an n-bit operand; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Unsigned N-bit adder with the carry-out returned as the sum MSB.
module adder_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq_nbit.sv
// Sequential shift-and-add unsigned multiplier with valid/ready on both sides.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips BUSY and goes straight to DONE.
module mult_seq_nbit
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = cnt_width(N);

    mult_state_t   state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  mcand;
    // The 2N+1-bit accumulator is {s, acc[N-1:0]} before each shift; its top
    // bit is always 0 afterwards, so only the low 2N bits are stored.
    logic [2*N-1:0] acc;
    logic [N:0]    sum;
    logic [N:0]    s;
    logic          accept;
    logic          zero_bypass;

    adder_nbit #(.N(N)) u_adder (
        .a   (acc[2*N-1:N]),
        .b   (mcand),
        .sum (sum)
    );

    assign accept = in_valid && in_ready;
    assign s      = acc[0] ? sum : {1'b0, acc[2*N-1:N]};

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_bypass = (a == '0) || (b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        product   = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = zero_bypass ? DONE : BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CW'(N-1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                product   = acc;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands load only in IDLE, so in_valid during BUSY/DONE cannot disturb
    // the result being computed or presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= a;
            acc   <= zero_bypass ? '0 : {{N{1'b0}}, b};
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc <= {s, acc[N-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_seq_nbit.sv
// Directed self-checking bench for mult_seq_nbit (N=8).
`timescale 1ns/1ps
module tb_mult_seq_nbit;

    localparam int N   = 8;
    localparam int LAT = N + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    mult_seq_nbit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic accept_op(input logic [N-1:0] aa, input logic [N-1:0] bb, input bit hold);
        a = aa;
        b = bb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // lat counts edges from the accept edge (inclusive) to the first out_valid sample.
    task automatic wait_done(output int lat, output logic [2*N-1:0] prod,
                             output bit saw_busy, output bit saw_rdy);
        lat      = 1;
        saw_busy = busy;
        saw_rdy  = in_ready;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            saw_busy |= busy;
            saw_rdy  |= in_ready;
        end
        prod = product;
        if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int             lat;
        logic [2*N-1:0] prod;
        bit             sb, sr, stable;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_product",   32'(product),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 13 * 11
        out_ready = 1'b1;
        accept_op(8'd13, 8'd11, 1'b0);
        wait_done(lat, prod, sb, sr);
        check("t1_product", 32'(prod), 32'd143);
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_in_ready_low", 32'(sr), 32'd0);
        check("t1_busy_seen", 32'(sb), 32'd1);
        @(posedge clk); @(negedge clk);
        check("t1_back_idle", 32'(in_ready), 32'd1);

        // 255 * 255 exercises the adder carry into the accumulator MSB
        accept_op(8'd255, 8'd255, 1'b0);
        wait_done(lat, prod, sb, sr);
        check("t2_product", 32'(prod), 32'd65025);
        @(posedge clk); @(negedge clk);

        // 200 * 3 with downstream stalled; new operands must be ignored
        out_ready = 1'b0;
        accept_op(8'd200, 8'd3, 1'b0);
        wait_done(lat, prod, sb, sr);
        check("t3_product", 32'(prod), 32'd600);
        a = 8'd1; b = 8'd1; in_valid = 1'b1;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            stable &= out_valid && (product == 16'd600) && !busy && !in_ready;
        end
        check("t3_hold_stable", 32'(stable), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("t3_released_valid", 32'(out_valid), 32'd0);
        check("t3_not_accepted", 32'(busy), 32'd0);

        // Back-to-back with in_valid held high: 7*6 then 100*100
        accept_op(8'd7, 8'd6, 1'b1);
        a = 8'd100; b = 8'd100;
        wait_done(lat, prod, sb, sr);
        check("t4_first_product", 32'(prod), 32'd42);
        check("t4_first_latency", 32'(lat), 32'(LAT));
        @(posedge clk); @(negedge clk);
        check("t4_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        check("t4_second_accepted", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_done(lat, prod, sb, sr);
        check("t4_second_product", 32'(prod), 32'd10000);
        check("t4_second_latency", 32'(lat), 32'(LAT));
        @(posedge clk); @(negedge clk);

        // Reset at BUSY cycle 4 of 9*9
        accept_op(8'd9, 8'd9, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",      32'(busy),      32'd0);
        check("t5_rst_in_ready",  32'(in_ready),  32'd1);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_product",   32'(product),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept_op(8'd2, 8'd5, 1'b0);
        wait_done(lat, prod, sb, sr);
        check("t5_after_rst_product", 32'(prod), 32'd10);
        check("t5_after_rst_latency", 32'(lat), 32'(LAT));
        @(posedge clk); @(negedge clk);

        // Zero operand
        accept_op(8'd0, 8'd77, 1'b0);
        wait_done(lat, prod, sb, sr);
        check("t6_product", 32'(prod), 32'd0);
`ifdef MULT_ZERO_BYPASS_EN
        check("t6_latency", 32'(lat), 32'd1);
        check("t6_busy_seen", 32'(sb), 32'd0);
`else
        check("t6_latency", 32'(lat), 32'(LAT));
        check("t6_busy_seen", 32'(sb), 32'd1);
`endif
        @(posedge clk); @(negedge clk);
        check("t6_back_idle", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
